// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline.
// Holds the base-ISA opcode constants, the common scalar typedefs, the
// immediate-format enum, the ID stage FSM states and the ID/EX bundle.
// Also provides small helpers that tell which source registers an opcode reads.
package core_pkg;

    localparam int DATA_W = 32;

    typedef logic [4:0]        RegId;
    typedef logic [DATA_W-1:0] Data;
    typedef logic              Bool;
    typedef logic              Clock;

    localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OPC_STORE    = 7'b010_0011;
    localparam logic [6:0] OPC_OP       = 7'b011_0011;
    localparam logic [6:0] OPC_LUI      = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
    localparam logic [6:0] OPC_JALR     = 7'b110_0111;
    localparam logic [6:0] OPC_JAL      = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } ImmType;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } StageState;

    typedef struct packed {
        Bool        valid;
        Data        pc;
        Data        rs1_val;
        Data        rs2_val;
        RegId       rs1_idx;
        RegId       rs2_idx;
        RegId       rd;
        Data        imm;
        logic [6:0] opcode;
        logic [2:0] funct3;
        Bool        funct7_b5;
        Bool        reg_write;
        Bool        is_load;
        Bool        illegal;
    } IdExBundle;

    // rs1 is read by everything except the PC/upper-immediate forms
    function automatic Bool uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic Bool uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator for RV32I.
// Purely combinational: classifies the opcode into an immediate format,
// builds the sign-extended immediate and flags opcodes outside the base set.
// Ports: instr (raw instruction) -> imm (sign-extended immediate),
//        illegal (opcode not an RV32I base opcode).
module imm_gen
    import core_pkg::*;
(
    input  logic [31:0] instr,
    output Data         imm,
    output Bool         illegal
);

    ImmType imm_type_s;

    // opcode -> immediate format and legality
    always_comb begin
        imm_type_s = IMM_NONE;
        illegal    = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_type_s = IMM_I;
            OPC_STORE:                      imm_type_s = IMM_S;
            OPC_BRANCH:                     imm_type_s = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_type_s = IMM_U;
            OPC_JAL:                        imm_type_s = IMM_J;
            OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: imm_type_s = IMM_NONE;
            default:                        illegal = 1'b1;
        endcase
    end

    // immediate assembly; every format sign-extends from instr[31]
    always_comb begin
        imm = 32'h0000_0000;
        case (imm_type_s)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage and ID/EX pipeline register of the 5-stage RV32I core.
// Drives the register-file read indices straight from the IF/ID instruction,
// decodes it, captures the returned operands and presents a valid/ready
// bundle to EX. A load in ID/EX whose rd feeds the next instruction causes
// exactly one bubble. flush from EX overrides everything.
// Ports: clk/rst (async active-high); if_valid/if_ready/if_instr/if_pc from
// IF/ID; rf_read_idx_*/rf_read_data_* to/from the register file; flush and
// ex_ready from EX; id_* registered bundle to EX.
// Optional: define DECODE_STALL_CNT_EN to add the stall_count output.
module decode_stage
    import core_pkg::*;
#(
    parameter int          XLEN      = DATA_W,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_read_idx_1,
    output logic [4:0]      rf_read_idx_2,
    input  logic [XLEN-1:0] rf_read_data_1,
    input  logic [XLEN-1:0] rf_read_data_2,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [4:0]      id_rs1_idx,
    output logic [4:0]      id_rs2_idx,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_imm,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic            id_funct7_b5,
    output logic            id_reg_write,
    output logic            id_is_load,
    output logic            id_illegal
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [31:0]     stall_count
`endif
);

    IdExBundle  id_r;
    IdExBundle  id_next_s;
    IdExBundle  bubble_s;
    IdExBundle  decoded_s;
    StageState  state_r;
    StageState  state_next_s;
    Data        imm_s;
    Bool        illegal_s;
    Bool        hazard_s;
    Bool        accept_s;
    logic [6:0] opc_s;

    assign opc_s         = if_instr[6:0];
    assign rf_read_idx_1 = if_instr[19:15];
    assign rf_read_idx_2 = if_instr[24:20];

    imm_gen u_imm_gen (
        .instr   (if_instr),
        .imm     (imm_s),
        .illegal (illegal_s)
    );

    // load-use detection against the bundle currently held in ID/EX
    assign hazard_s = id_r.valid && id_r.is_load && (id_r.rd != 5'd0) &&
                      (((id_r.rd == if_instr[19:15]) && uses_rs1(opc_s)) ||
                       ((id_r.rd == if_instr[24:20]) && uses_rs2(opc_s)));

    // flush consumes (and discards) whatever IF/ID offers
    assign if_ready = flush || (!hazard_s && (!id_r.valid || ex_ready));
    assign accept_s = if_valid && if_ready;

    // bubble is the NOP decode with no operands; also the reset image
    always_comb begin
        bubble_s           = '0;
        bubble_s.opcode    = NOP_INSTR[6:0];
        bubble_s.funct3    = NOP_INSTR[14:12];
        bubble_s.imm       = {{20{NOP_INSTR[31]}}, NOP_INSTR[31:20]};
    end

    // decode of the instruction offered by IF/ID
    always_comb begin
        decoded_s           = '0;
        decoded_s.valid     = 1'b1;
        decoded_s.pc        = if_pc;
        decoded_s.rs1_val   = rf_read_data_1;
        decoded_s.rs2_val   = rf_read_data_2;
        decoded_s.rs1_idx   = if_instr[19:15];
        decoded_s.rs2_idx   = if_instr[24:20];
        decoded_s.rd        = if_instr[11:7];
        decoded_s.imm       = imm_s;
        decoded_s.opcode    = opc_s;
        decoded_s.funct3    = if_instr[14:12];
        decoded_s.funct7_b5 = if_instr[30];
        decoded_s.is_load   = (opc_s == OPC_LOAD);
        decoded_s.illegal   = illegal_s;
        decoded_s.reg_write = !illegal_s && (if_instr[11:7] != 5'd0) &&
                              (opc_s != OPC_STORE) && (opc_s != OPC_BRANCH) &&
                              (opc_s != OPC_SYSTEM);
    end

    // FSM next state: one-cycle STALL after a bubble is inserted
    always_comb begin
        state_next_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (!flush && hazard_s && ex_ready) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STALL: state_next_s = ST_RUN;
            default:  state_next_s = ST_RUN;
        endcase
    end

    // ID/EX next contents, highest priority first
    always_comb begin
        id_next_s = id_r;
        if (flush) begin
            id_next_s = bubble_s;
        end else if (hazard_s && ex_ready) begin
            id_next_s = bubble_s;
        end else if (accept_s) begin
            id_next_s = decoded_s;
        end else if (ex_ready) begin
            id_next_s = bubble_s;
        end else begin
            id_next_s = id_r;
        end
    end

    // pipeline register and FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r    <= bubble_s;
            state_r <= ST_RUN;
        end else begin
            id_r    <= id_next_s;
            state_r <= state_next_s;
        end
    end

`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // counts RUN->STALL transitions, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r == ST_RUN) && (state_next_s == ST_STALL)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;
`endif

    assign id_valid     = id_r.valid;
    assign id_pc        = id_r.pc;
    assign id_rs1_val   = id_r.rs1_val;
    assign id_rs2_val   = id_r.rs2_val;
    assign id_rs1_idx   = id_r.rs1_idx;
    assign id_rs2_idx   = id_r.rs2_idx;
    assign id_rd        = id_r.rd;
    assign id_imm       = id_r.imm;
    assign id_opcode    = id_r.opcode;
    assign id_funct3    = id_r.funct3;
    assign id_funct7_b5 = id_r.funct7_b5;
    assign id_reg_write = id_r.reg_write;
    assign id_is_load   = id_r.is_load;
    assign id_illegal   = id_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_decode_stage;

    localparam logic [6:0] T_LOAD   = 7'h03;
    localparam logic [6:0] T_FENCE  = 7'h0F;
    localparam logic [6:0] T_OPIMM  = 7'h13;
    localparam logic [6:0] T_AUIPC  = 7'h17;
    localparam logic [6:0] T_STORE  = 7'h23;
    localparam logic [6:0] T_OP     = 7'h33;
    localparam logic [6:0] T_LUI    = 7'h37;
    localparam logic [6:0] T_BRANCH = 7'h63;
    localparam logic [6:0] T_JALR   = 7'h67;
    localparam logic [6:0] T_JAL    = 7'h6F;
    localparam logic [6:0] T_SYSTEM = 7'h73;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instr = 32'h0000_0013;
    logic [31:0] if_pc = 32'h0;
    logic [4:0]  rf_read_idx_1, rf_read_idx_2;
    logic [31:0] rf_read_data_1 = 32'h0, rf_read_data_2 = 32'h0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7_b5, id_reg_write, id_is_load, id_illegal;
`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rf_read_idx_1(rf_read_idx_1), .rf_read_idx_2(rf_read_idx_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rd(id_rd), .id_imm(id_imm),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_illegal(id_illegal)
`ifdef DECODE_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state: contents of ID/EX as the ISA rules say they should be
    logic        m_valid;
    logic [31:0] m_pc, m_v1, m_v2, m_imm, m_cnt;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_f7, m_rw, m_ld, m_ill;
    logic        m_rdy;
    logic        obs_rdy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] opc);
        return opc inside {T_LOAD, T_FENCE, T_OPIMM, T_AUIPC, T_STORE, T_OP,
                           T_LUI, T_BRANCH, T_JALR, T_JAL, T_SYSTEM};
    endfunction

    function automatic logic reads_rs1(input logic [6:0] opc);
        return !(opc inside {T_LUI, T_AUIPC, T_JAL});
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return opc inside {T_OP, T_STORE, T_BRANCH};
    endfunction

    // immediates from weighted instruction fields (two's complement via the sign term)
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [31:0] sgn;
        sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
        case (ins[6:0])
            T_LOAD, T_OPIMM, T_JALR:
                return sgn * 32'd2048 + 32'(ins[30:20]);
            T_STORE:
                return sgn * 32'd2048 + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:7]);
            T_BRANCH:
                return sgn * 32'd4096 + 32'(ins[7]) * 32'd2048 + 32'(ins[30:25]) * 32'd32
                       + 32'(ins[11:8]) * 32'd2;
            T_LUI, T_AUIPC:
                return ins & 32'hFFFF_F000;
            T_JAL:
                return sgn * 32'd1048576 + 32'(ins[19:12]) * 32'd4096 + 32'(ins[20]) * 32'd2048
                       + 32'(ins[30:21]) * 32'd2;
            default:
                return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pc = 32'h0; m_v1 = 32'h0; m_v2 = 32'h0; m_imm = 32'h0;
        m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_opc = T_OPIMM; m_f3 = 3'd0;
        m_f7 = 1'b0; m_rw = 1'b0; m_ld = 1'b0; m_ill = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic check_reset_state();
        check_val("rst_valid", 32'(id_valid), 32'h0);
        check_val("rst_pc", id_pc, 32'h0);
        check_val("rst_rs1_val", id_rs1_val, 32'h0);
        check_val("rst_rs2_val", id_rs2_val, 32'h0);
        check_val("rst_rs1_idx", 32'(id_rs1_idx), 32'h0);
        check_val("rst_rs2_idx", 32'(id_rs2_idx), 32'h0);
        check_val("rst_rd", 32'(id_rd), 32'h0);
        check_val("rst_imm", id_imm, 32'h0);
        check_val("rst_opcode", 32'(id_opcode), 32'h13);
        check_val("rst_funct3", 32'(id_funct3), 32'h0);
        check_val("rst_f7b5", 32'(id_funct7_b5), 32'h0);
        check_val("rst_reg_write", 32'(id_reg_write), 32'h0);
        check_val("rst_is_load", 32'(id_is_load), 32'h0);
        check_val("rst_illegal", 32'(id_illegal), 32'h0);
`ifdef DECODE_STALL_CNT_EN
        check_val("rst_stall_count", stall_count, 32'h0);
`endif
    endtask

    task automatic check_outputs();
        check_val("id_valid", 32'(id_valid), 32'(m_valid));
        if (m_valid) begin
            check_val("id_pc", id_pc, m_pc);
            check_val("id_rs1_val", id_rs1_val, m_v1);
            check_val("id_rs2_val", id_rs2_val, m_v2);
            check_val("id_rs1_idx", 32'(id_rs1_idx), 32'(m_rs1));
            check_val("id_rs2_idx", 32'(id_rs2_idx), 32'(m_rs2));
            check_val("id_rd", 32'(id_rd), 32'(m_rd));
            check_val("id_imm", id_imm, m_imm);
            check_val("id_opcode", 32'(id_opcode), 32'(m_opc));
            check_val("id_funct3", 32'(id_funct3), 32'(m_f3));
            check_val("id_f7b5", 32'(id_funct7_b5), 32'(m_f7));
            check_val("id_reg_write", 32'(id_reg_write), 32'(m_rw));
            check_val("id_is_load", 32'(id_is_load), 32'(m_ld));
            check_val("id_illegal", 32'(id_illegal), 32'(m_ill));
        end
`ifdef DECODE_STALL_CNT_EN
        check_val("stall_count", stall_count, m_cnt);
`endif
    endtask

    // one clock: drive at negedge, check combinational outputs, step the model at posedge
    task automatic do_cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                            input logic fl, input logic er);
        logic hz;
        logic [6:0] opc;
        @(negedge clk);
        if_valid = iv; if_instr = ins; if_pc = pc; flush = fl; ex_ready = er;
        rf_read_data_1 = $urandom; rf_read_data_2 = $urandom;
        #1;
        opc = ins[6:0];
        hz = m_valid && m_ld && (m_rd != 5'd0) &&
             (((m_rd == ins[19:15]) && reads_rs1(opc)) || ((m_rd == ins[24:20]) && reads_rs2(opc)));
        m_rdy = fl || (!hz && (!m_valid || er));
        obs_rdy = if_ready;
        check_val("if_ready", 32'(if_ready), 32'(m_rdy));
        check_val("rf_idx_1", 32'(rf_read_idx_1), 32'(ins[19:15]));
        check_val("rf_idx_2", 32'(rf_read_idx_2), 32'(ins[24:20]));
        if (fl) begin
            m_valid = 1'b0;
        end else if (hz && er) begin
            m_valid = 1'b0;
            m_cnt = m_cnt + 32'd1;
        end else if (iv && m_rdy) begin
            m_valid = 1'b1; m_pc = pc; m_v1 = rf_read_data_1; m_v2 = rf_read_data_2;
            m_rs1 = ins[19:15]; m_rs2 = ins[24:20]; m_rd = ins[11:7];
            m_imm = ref_imm(ins); m_opc = opc; m_f3 = ins[14:12]; m_f7 = ins[30];
            m_ld = (opc == T_LOAD); m_ill = !is_legal(opc);
            m_rw = is_legal(opc) && (ins[11:7] != 5'd0) && !(opc inside {T_STORE, T_BRANCH, T_SYSTEM});
        end else if (er) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] table_opc [11];
        int k;
        table_opc = '{T_LOAD, T_FENCE, T_OPIMM, T_AUIPC, T_STORE, T_OP,
                      T_LUI, T_BRANCH, T_JALR, T_JAL, T_SYSTEM};
        k = $urandom_range(0, 13);
        if (k < 11) opc = table_opc[k];
        else if (k == 11) opc = T_LOAD;
        else opc = 7'($urandom);
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), opc};
    endfunction

    localparam logic [31:0] LW_X5   = 32'h0000_A283;
    localparam logic [31:0] ADD_X5  = 32'h0022_8333;
    localparam logic [31:0] LW_X0   = 32'h0000_A003;
    localparam logic [31:0] ADD_X0  = 32'h0020_0333;
    localparam logic [31:0] BEQ_M4  = 32'hFE20_8EE3;
    localparam logic [31:0] LUI_X3  = 32'h1234_51B7;
    localparam logic [31:0] ADDI_X1 = 32'h0010_0093;
    localparam logic [31:0] ADDI_X2 = 32'h0020_0113;

    initial begin
        logic [31:0] cnt0;
        logic [31:0] cur_instr;
        logic [31:0] cur_pc;
        logic        iv;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;

        // load-use on rs1: one bubble, if_ready low for one cycle
        cnt0 = m_cnt;
        do_cycle(1'b1, LW_X5, 32'h100, 1'b0, 1'b1);
        check_val("lu_valid_1", 32'(id_valid), 32'h1);
        do_cycle(1'b1, ADD_X5, 32'h104, 1'b0, 1'b1);
        check_val("lu_ready_low", 32'(obs_rdy), 32'h0);
        check_val("lu_valid_0", 32'(id_valid), 32'h0);
        do_cycle(1'b1, ADD_X5, 32'h104, 1'b0, 1'b1);
        check_val("lu_ready_back", 32'(obs_rdy), 32'h1);
        check_val("lu_valid_2", 32'(id_valid), 32'h1);
        check_val("lu_pc", id_pc, 32'h104);
`ifdef DECODE_STALL_CNT_EN
        check_val("lu_stall_count", stall_count, cnt0 + 32'd1);
`endif

        // lw to x0 must not stall
        do_cycle(1'b1, LW_X0, 32'h200, 1'b0, 1'b1);
        do_cycle(1'b1, ADD_X0, 32'h204, 1'b0, 1'b1);
        check_val("x0_ready", 32'(obs_rdy), 32'h1);
        check_val("x0_valid", 32'(id_valid), 32'h1);
        check_val("x0_pc", id_pc, 32'h204);

        // immediate decode
        do_cycle(1'b1, BEQ_M4, 32'h300, 1'b0, 1'b1);
        check_val("beq_imm", id_imm, 32'hFFFF_FFFC);
        check_val("beq_rw", 32'(id_reg_write), 32'h0);
        do_cycle(1'b1, LUI_X3, 32'h304, 1'b0, 1'b1);
        check_val("lui_imm", id_imm, 32'h1234_5000);
        check_val("lui_rw", 32'(id_reg_write), 32'h1);

        // backpressure: hold for 3 cycles, next instruction one cycle after release
        do_cycle(1'b1, ADDI_X1, 32'h400, 1'b0, 1'b1);
        repeat (3) begin
            do_cycle(1'b1, ADDI_X2, 32'h404, 1'b0, 1'b0);
            check_val("bp_ready", 32'(obs_rdy), 32'h0);
            check_val("bp_pc_hold", id_pc, 32'h400);
            check_val("bp_valid", 32'(id_valid), 32'h1);
        end
        do_cycle(1'b1, ADDI_X2, 32'h404, 1'b0, 1'b1);
        check_val("bp_release_pc", id_pc, 32'h404);

        // flush in the cycle after the bubble
        do_cycle(1'b1, LW_X5, 32'h500, 1'b0, 1'b1);
        do_cycle(1'b1, ADD_X5, 32'h504, 1'b0, 1'b1);
        cnt0 = m_cnt;
        do_cycle(1'b1, ADD_X5, 32'h504, 1'b1, 1'b1);
        check_val("fl_ready", 32'(obs_rdy), 32'h1);
        check_val("fl_valid", 32'(id_valid), 32'h0);
        do_cycle(1'b1, ADDI_X1, 32'h600, 1'b0, 1'b1);
        check_val("fl_resume", 32'(id_valid), 32'h1);
`ifdef DECODE_STALL_CNT_EN
        check_val("fl_count", stall_count, cnt0);
`endif

        // flush coinciding with the hazard suppresses the stall
        do_cycle(1'b1, LW_X5, 32'h700, 1'b0, 1'b1);
        cnt0 = m_cnt;
        do_cycle(1'b1, ADD_X5, 32'h704, 1'b1, 1'b1);
        check_val("flh_ready", 32'(obs_rdy), 32'h1);
        check_val("flh_valid", 32'(id_valid), 32'h0);
`ifdef DECODE_STALL_CNT_EN
        check_val("flh_count", stall_count, cnt0);
`endif

        // async reset mid-cycle while a bundle is valid
        do_cycle(1'b1, ADDI_X1, 32'h800, 1'b0, 1'b1);
        check_val("ar_pre_valid", 32'(id_valid), 32'h1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("ar_valid_now", 32'(id_valid), 32'h0);
        check_reset_state();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic; IF/ID holds its instruction until accepted
        cur_instr = rand_instr();
        cur_pc = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            iv = ($urandom_range(0, 9) < 8);
            do_cycle(iv, cur_instr, cur_pc, ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 3) != 0));
            if (iv && m_rdy) begin
                cur_instr = rand_instr();
                cur_pc = cur_pc + 32'd4;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
